// File: rtl/watch_scanner.sv
// rtl/watch_scanner.sv - walks both watch lists of a falsified literal, drives the
// clause evaluator, and issues watch moves, unit implications or a conflict report.
module watch_scanner #(
  parameter int MAX_CLAUSES = 256,
  parameter int MAX_VARS    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] scan_idx,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        conflict,
  output logic [15:0] conflict_clause_id,
  output logic        loop_err,
  output logic [15:0] rd_head_idx,
  input  logic [15:0] rd_head1,
  input  logic [15:0] rd_head2,
  output logic [15:0] rd_clause_id,
  input  logic [15:0] rd_w1,
  input  logic [15:0] rd_w2,
  input  logic [15:0] rd_next1,
  input  logic [15:0] rd_next2,
  output logic        eval_req,
  output logic [15:0] eval_clause_id,
  output logic [15:0] eval_false_w,
  output logic [15:0] eval_other_w,
  input  logic        eval_ack,
  input  logic [1:0]  eval_result,
  input  logic [15:0] eval_new_w,
  input  logic [15:0] eval_new_idx,
  output logic        move_en,
  output logic [15:0] move_clause_id,
  output logic        move_list_sel,
  output logic [15:0] move_new_w,
  output logic [15:0] move_old_idx,
  output logic [15:0] move_new_idx,
  output logic [15:0] move_prev_id,
  output logic        unit_valid,
  input  logic        unit_ready,
  output logic [15:0] unit_lit,
  output logic [15:0] unit_clause_id
);

  localparam logic [15:0] NIL        = 16'hFFFF;
  localparam logic [16:0] IDX_LIMIT  = 17'(2 * MAX_VARS);
  localparam logic [16:0] ITER_LIMIT = 17'(MAX_CLAUSES);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_FETCH, S_EVAL, S_MOVE, S_UNIT, S_NEXT, S_DONE
  } state_t;

  state_t      state;
  logic        sel;
  logic [15:0] scan_q;
  logic [15:0] cur;
  logic [15:0] prev;
  logic [15:0] nxt;
  logic [16:0] iter;
  logic [16:0] iter_inc;
  logic [15:0] head_sel;

  assign iter_inc = iter + 17'd1;
  assign head_sel = sel ? rd_head2 : rd_head1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      sel                <= 1'b0;
      scan_q             <= 16'd0;
      cur                <= 16'd0;
      prev               <= NIL;
      nxt                <= NIL;
      iter               <= 17'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
      conflict           <= 1'b0;
      conflict_clause_id <= NIL;
      loop_err           <= 1'b0;
      rd_head_idx        <= NIL;
      rd_clause_id       <= NIL;
      eval_req           <= 1'b0;
      eval_clause_id     <= 16'd0;
      eval_false_w       <= 16'd0;
      eval_other_w       <= 16'd0;
      move_en            <= 1'b0;
      move_clause_id     <= 16'd0;
      move_list_sel      <= 1'b0;
      move_new_w         <= 16'd0;
      move_old_idx       <= 16'd0;
      move_new_idx       <= 16'd0;
      move_prev_id       <= NIL;
      unit_valid         <= 1'b0;
      unit_lit           <= 16'd0;
      unit_clause_id     <= 16'd0;
    end else if (abort && state != S_IDLE) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      conflict   <= 1'b0;
      loop_err   <= 1'b0;
      eval_req   <= 1'b0;
      unit_valid <= 1'b0;
      move_en    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            scan_q <= scan_idx;
            sel    <= 1'b0;
            prev   <= NIL;
            if ({1'b0, scan_idx} >= IDX_LIMIT) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy        <= 1'b1;
              rd_head_idx <= scan_idx;
              state       <= S_HEAD;
            end
          end
        end

        // Clearing nxt here lets an empty list fall straight through NEXT.
        S_HEAD: begin
          cur  <= head_sel;
          nxt  <= NIL;
          iter <= 17'd0;
          if (head_sel == NIL) begin
            state <= S_NEXT;
          end else begin
            rd_clause_id <= head_sel;
            state        <= S_FETCH;
          end
        end

        // The successor is captured now because a later move rewrites next[cur].
        S_FETCH: begin
          nxt            <= sel ? rd_next2 : rd_next1;
          eval_clause_id <= cur;
          eval_false_w   <= sel ? rd_w2 : rd_w1;
          eval_other_w   <= sel ? rd_w1 : rd_w2;
          eval_req       <= 1'b1;
          state          <= S_EVAL;
        end

        S_EVAL: begin
          if (eval_ack) begin
            eval_req <= 1'b0;
            case (eval_result)
              2'd0: begin
                prev  <= cur;
                state <= S_NEXT;
              end
              2'd1: begin
                move_en        <= 1'b1;
                move_clause_id <= cur;
                move_list_sel  <= sel;
                move_new_w     <= eval_new_w;
                move_old_idx   <= scan_q;
                move_new_idx   <= eval_new_idx;
                move_prev_id   <= prev;
                state          <= S_MOVE;
              end
              2'd2: begin
                unit_valid     <= 1'b1;
                unit_lit       <= eval_other_w;
                unit_clause_id <= cur;
                state          <= S_UNIT;
              end
              default: begin
                conflict           <= 1'b1;
                conflict_clause_id <= cur;
                done               <= 1'b1;
                busy               <= 1'b0;
                state              <= S_DONE;
              end
            endcase
          end
        end

        // A move back into the same list keeps the clause as the new predecessor.
        S_MOVE: begin
          move_en <= 1'b0;
          if (move_new_idx == scan_q) prev <= cur;
          state <= S_NEXT;
        end

        S_UNIT: begin
          if (unit_ready) begin
            unit_valid <= 1'b0;
            prev       <= cur;
            state      <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (iter_inc >= ITER_LIMIT) begin
            loop_err <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
          end else if (nxt != NIL) begin
            cur          <= nxt;
            rd_clause_id <= nxt;
            iter         <= iter_inc;
            state        <= S_FETCH;
          end else if (!sel) begin
            sel   <= 1'b1;
            prev  <= NIL;
            state <= S_HEAD;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done     <= 1'b0;
          conflict <= 1'b0;
          loop_err <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_watch_scanner.sv
// tb/tb_watch_scanner.sv - randomized bench for watch_scanner with a list-walking
// reference model, a modelled watch storage and a randomized-latency evaluator.
`timescale 1ns/1ps
module tb_watch_scanner;

  localparam int MAXC = 24;
  localparam int MAXV = 16;
  localparam int NIDX = 2 * MAXV;
  localparam int NCL  = 64;
  localparam logic [15:0] NIL = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] scan_idx;
  logic        busy, done, conflict, loop_err;
  logic [15:0] conflict_clause_id;
  logic [15:0] rd_head_idx, rd_head1, rd_head2, rd_clause_id;
  logic [15:0] rd_w1, rd_w2, rd_next1, rd_next2;
  logic        eval_req, eval_ack;
  logic [15:0] eval_clause_id, eval_false_w, eval_other_w, eval_new_w, eval_new_idx;
  logic [1:0]  eval_result;
  logic        move_en, move_list_sel;
  logic [15:0] move_clause_id, move_new_w, move_old_idx, move_new_idx, move_prev_id;
  logic        unit_valid, unit_ready;
  logic [15:0] unit_lit, unit_clause_id;

  always #5 clk = ~clk;

  watch_scanner #(.MAX_CLAUSES(MAXC), .MAX_VARS(MAXV)) dut (
    .clk(clk), .rst(rst), .start(start), .scan_idx(scan_idx), .abort(abort),
    .busy(busy), .done(done), .conflict(conflict),
    .conflict_clause_id(conflict_clause_id), .loop_err(loop_err),
    .rd_head_idx(rd_head_idx), .rd_head1(rd_head1), .rd_head2(rd_head2),
    .rd_clause_id(rd_clause_id), .rd_w1(rd_w1), .rd_w2(rd_w2),
    .rd_next1(rd_next1), .rd_next2(rd_next2),
    .eval_req(eval_req), .eval_clause_id(eval_clause_id),
    .eval_false_w(eval_false_w), .eval_other_w(eval_other_w),
    .eval_ack(eval_ack), .eval_result(eval_result),
    .eval_new_w(eval_new_w), .eval_new_idx(eval_new_idx),
    .move_en(move_en), .move_clause_id(move_clause_id),
    .move_list_sel(move_list_sel), .move_new_w(move_new_w),
    .move_old_idx(move_old_idx), .move_new_idx(move_new_idx),
    .move_prev_id(move_prev_id),
    .unit_valid(unit_valid), .unit_ready(unit_ready),
    .unit_lit(unit_lit), .unit_clause_id(unit_clause_id)
  );

  // Watch storage and evaluator decision tables
  logic [15:0] head1[NIDX], head2[NIDX];
  logic [15:0] w1[NCL], w2[NCL], nx1[NCL], nx2[NCL];
  logic [1:0]  res_tab[NCL];
  logic [15:0] nidx_tab[NCL], nw_tab[NCL];

  always_comb begin
    rd_head1 = NIL;
    rd_head2 = NIL;
    rd_w1    = NIL;
    rd_w2    = NIL;
    rd_next1 = NIL;
    rd_next2 = NIL;
    if (int'(rd_head_idx) < NIDX) begin
      rd_head1 = head1[int'(rd_head_idx)];
      rd_head2 = head2[int'(rd_head_idx)];
    end
    if (int'(rd_clause_id) < NCL) begin
      rd_w1    = w1[int'(rd_clause_id)];
      rd_w2    = w2[int'(rd_clause_id)];
      rd_next1 = nx1[int'(rd_clause_id)];
      rd_next2 = nx2[int'(rd_clause_id)];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [95:0] exp_ev[$], exp_mv[$], exp_un[$];
  logic [95:0] got_ev[$], got_mv[$], got_un[$];
  logic        exp_conf, exp_loop, got_conf, got_loop;
  logic [15:0] exp_cid, got_cid;
  int          got_done, busy_cnt, uv_cnt, overlap_cnt, un_unstable;
  int          eval_hold = -1;
  int          unit_hold = -1;

  // Evaluator, implication sink, storage move port and observation, all at negedge
  initial begin
    int ev_cnt, un_cnt, c, mc, oi, ni;
    bit ev_pend, un_pend;
    logic [31:0] un_first;
    ev_pend = 0; un_pend = 0; ev_cnt = 0; un_cnt = 0; un_first = 0;
    eval_ack = 0; eval_result = 0; eval_new_w = 0; eval_new_idx = 0; unit_ready = 0;
    forever begin
      @(negedge clk);
      if (eval_req) begin
        if (!ev_pend) begin
          ev_pend = 1;
          ev_cnt  = (eval_hold < 0) ? int'($urandom_range(0, 2)) : eval_hold;
        end
        if (ev_cnt == 0) begin
          c = int'(eval_clause_id) % NCL;
          eval_ack     = 1;
          eval_result  = res_tab[c];
          eval_new_w   = nw_tab[c];
          eval_new_idx = nidx_tab[c];
          got_ev.push_back({48'd0, eval_clause_id, eval_false_w, eval_other_w});
          ev_pend = 0;
        end else begin
          eval_ack = 0;
          ev_cnt--;
        end
      end else begin
        eval_ack = 0;
        ev_pend  = 0;
      end

      if (unit_valid) begin
        uv_cnt++;
        if (!un_pend) begin
          un_pend  = 1;
          un_cnt   = (unit_hold < 0) ? int'($urandom_range(0, 3)) : unit_hold;
          un_first = {unit_lit, unit_clause_id};
        end
        if ({unit_lit, unit_clause_id} != un_first) un_unstable++;
        if (un_cnt == 0) begin
          unit_ready = 1;
          got_un.push_back({64'd0, unit_lit, unit_clause_id});
          un_pend = 0;
        end else begin
          unit_ready = 0;
          un_cnt--;
        end
      end else begin
        unit_ready = 0;
        un_pend    = 0;
      end

      if (move_en) begin
        got_mv.push_back({15'd0, move_clause_id, move_list_sel, move_new_w,
                          move_old_idx, move_new_idx, move_prev_id});
        if (eval_req || unit_valid) overlap_cnt++;
        mc = int'(move_clause_id) % NCL;
        oi = int'(move_old_idx);
        ni = int'(move_new_idx);
        if (!move_list_sel) begin
          w1[mc] = move_new_w;
          if (ni != oi && oi < NIDX && ni < NIDX) begin
            if (move_prev_id == NIL) head1[oi] = nx1[mc];
            else nx1[int'(move_prev_id) % NCL] = nx1[mc];
            nx1[mc] = head1[ni];
            head1[ni] = move_clause_id;
          end
        end else begin
          w2[mc] = move_new_w;
          if (ni != oi && oi < NIDX && ni < NIDX) begin
            if (move_prev_id == NIL) head2[oi] = nx2[mc];
            else nx2[int'(move_prev_id) % NCL] = nx2[mc];
            nx2[mc] = head2[ni];
            head2[ni] = move_clause_id;
          end
        end
      end

      if (busy) busy_cnt++;
      if (done) begin
        got_done++;
        got_conf = conflict;
        got_cid  = conflict_clause_id;
        got_loop = loop_err;
      end
    end
  end

  // Reference: walk each list from the pre-scan storage and apply the result rules
  task automatic model_scan(input int idx);
    logic [15:0] c, p, fw, ow;
    int n, ci;
    exp_ev.delete(); exp_mv.delete(); exp_un.delete();
    exp_conf = 0; exp_loop = 0; exp_cid = NIL;
    if (idx >= NIDX) return;
    for (int s = 0; s < 2; s++) begin
      c = (s == 1) ? head2[idx] : head1[idx];
      p = NIL;
      n = 0;
      while (c != NIL) begin
        ci = int'(c);
        fw = (s == 1) ? w2[ci] : w1[ci];
        ow = (s == 1) ? w1[ci] : w2[ci];
        exp_ev.push_back({48'd0, c, fw, ow});
        case (res_tab[ci])
          2'd0: p = c;
          2'd1: begin
            exp_mv.push_back({15'd0, c, 1'(s), nw_tab[ci], 16'(idx), nidx_tab[ci], p});
            if (nidx_tab[ci] == 16'(idx)) p = c;
          end
          2'd2: begin
            exp_un.push_back({64'd0, ow, c});
            p = c;
          end
          default: begin
            exp_conf = 1;
            exp_cid  = c;
            return;
          end
        endcase
        n++;
        if (n >= MAXC) begin
          exp_loop = 1;
          return;
        end
        c = (s == 1) ? nx2[ci] : nx1[ci];
      end
    end
  endtask

  task automatic clear_store();
    for (int i = 0; i < NIDX; i++) begin
      head1[i] = NIL;
      head2[i] = NIL;
    end
    for (int i = 0; i < NCL; i++) begin
      w1[i] = 16'($urandom_range(0, 511));
      w2[i] = 16'($urandom_range(0, 511));
      nx1[i] = NIL;
      nx2[i] = NIL;
      res_tab[i] = 2'd0;
      nidx_tab[i] = 16'd0;
      nw_tab[i] = 16'($urandom_range(0, 511));
    end
  endtask

  task automatic put_list(input bit s, input int idx, input int a, input int b, input int c);
    int ids[3];
    logic [15:0] h;
    ids[0] = a; ids[1] = b; ids[2] = c;
    h = NIL;
    for (int i = 2; i >= 0; i--) begin
      if (ids[i] >= 0) begin
        if (s) nx2[ids[i]] = h;
        else nx1[ids[i]] = h;
        h = 16'(ids[i]);
      end
    end
    if (s) head2[idx] = h;
    else head1[idx] = h;
  endtask

  task automatic rand_store(output int idx);
    int perm[NCL];
    int pos, len, j, t, r;
    logic [15:0] h;
    clear_store();
    for (int i = 0; i < NCL; i++) perm[i] = i;
    for (int i = NCL - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    idx = int'($urandom_range(0, NIDX - 1));
    pos = 0;
    for (int s = 0; s < 2; s++) begin
      len = int'($urandom_range(0, 6));
      h = NIL;
      for (int k = len - 1; k >= 0; k--) begin
        if (s == 1) nx2[perm[pos + k]] = h;
        else nx1[perm[pos + k]] = h;
        h = 16'(perm[pos + k]);
      end
      if (s == 1) head2[idx] = h;
      else head1[idx] = h;
      pos += len;
    end
    for (int i = 0; i < NCL; i++) begin
      r = int'($urandom_range(0, 9));
      res_tab[i]  = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      nidx_tab[i] = ($urandom_range(0, 3) == 0) ? 16'(idx) : 16'($urandom_range(0, NIDX - 1));
    end
  endtask

  task automatic run_scan(input string tag, input int idx, input bit poke);
    model_scan(idx);
    got_ev.delete(); got_mv.delete(); got_un.delete();
    got_done = 0; busy_cnt = 0; uv_cnt = 0; overlap_cnt = 0; un_unstable = 0;
    got_conf = 0; got_loop = 0; got_cid = 0;
    @(posedge clk); #1;
    start = 1;
    scan_idx = 16'(idx);
    @(posedge clk); #1;
    start = 0;
    scan_idx = 16'($urandom);
    for (int k = 0; k < 4000 && got_done == 0; k++) begin
      if (poke && k == 2 && busy) start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    check({tag, "_done_cnt"}, got_done, 1);
    check({tag, "_done_clear"}, {done, conflict, loop_err}, 3'b000);
    check({tag, "_n_eval"}, got_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
      check({tag, "_eval"}, got_ev[i], exp_ev[i]);
    check({tag, "_n_move"}, got_mv.size(), exp_mv.size());
    for (int i = 0; i < exp_mv.size() && i < got_mv.size(); i++)
      check({tag, "_move"}, got_mv[i], exp_mv[i]);
    check({tag, "_n_unit"}, got_un.size(), exp_un.size());
    for (int i = 0; i < exp_un.size() && i < got_un.size(); i++)
      check({tag, "_unit"}, got_un[i], exp_un[i]);
    check({tag, "_conflict"}, got_conf, exp_conf);
    check({tag, "_loop_err"}, got_loop, exp_loop);
    if (exp_conf) check({tag, "_conflict_id"}, got_cid, exp_cid);
    check({tag, "_move_overlap"}, overlap_cnt, 0);
  endtask

  initial begin
    int idx;
    rst = 1; start = 0; abort = 0; scan_idx = 0;
    clear_store();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check("rst_ctrl", {busy, done, conflict, loop_err, eval_req, move_en, unit_valid}, 7'd0);
    check("rst_rd_head_idx", rd_head_idx, NIL);
    check("rst_rd_clause_id", rd_clause_id, NIL);
    check("rst_move_prev_id", move_prev_id, NIL);
    check("rst_conflict_id", conflict_clause_id, NIL);

    clear_store();
    run_scan("empty", 5, 0);
    check("empty_busy_cycles", busy_cnt, 4);

    clear_store();
    put_list(0, 3, 7, -1, -1);
    run_scan("keep", 3, 0);

    clear_store();
    put_list(0, 3, 2, 9, 4);
    res_tab[9] = 2'd1; nidx_tab[9] = 16'd10;
    res_tab[4] = 2'd1; nidx_tab[4] = 16'd12;
    run_scan("replace", 3, 0);
    check("replace_prev_kept", (got_mv.size() == 2) ? got_mv[1][15:0] : 96'hDEAD, 16'd2);

    clear_store();
    put_list(1, 6, 11, -1, -1);
    res_tab[11] = 2'd2;
    w1[11] = 16'h0055;
    w2[11] = 16'h0066;
    unit_hold = 5;
    run_scan("unit", 6, 1);
    unit_hold = -1;
    check("unit_valid_cycles", uv_cnt, 6);
    check("unit_stable", un_unstable, 0);
    check("unit_lit", (got_un.size() > 0) ? got_un[0][31:16] : 96'hDEAD, 16'h0055);

    clear_store();
    put_list(0, 7, 1, 2, -1);
    put_list(1, 7, 20, -1, -1);
    res_tab[1] = 2'd3;
    run_scan("conflict", 7, 0);

    clear_store();
    run_scan("out_of_range", NIDX, 0);
    check("oor_busy_cycles", busy_cnt, 0);

    clear_store();
    head1[8] = 16'd8;
    nx1[8]   = 16'd8;
    run_scan("loop", 8, 0);

    clear_store();
    put_list(0, 4, 13, -1, -1);
    res_tab[13] = 2'd1;
    nidx_tab[13] = 16'd9;
    eval_hold = 10;
    got_mv.delete();
    got_done = 0;
    @(posedge clk); #1;
    start = 1;
    scan_idx = 16'd4;
    @(posedge clk); #1;
    start = 0;
    for (int k = 0; k < 20 && !eval_req; k++) begin
      @(posedge clk); #1;
    end
    check("abort_req_seen", eval_req, 1'b1);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("abort_idle", {eval_req, busy, move_en}, 3'b000);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", got_done, 0);
    check("abort_no_move", got_mv.size(), 0);
    eval_hold = -1;

    for (int t = 0; t < 25; t++) begin
      rand_store(idx);
      run_scan("rand", idx, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
